// File: rtl/jtag_tap_ctrl_if.sv
// rtl/jtag_tap_ctrl_if.sv - JTAG pin side and boundary-scan control bundle of the TAP controller
interface jtag_tap_ctrl_if #(
    parameter int IR_WIDTH = 4
) ();
    logic                TMS;
    logic                TDI;
    logic                DR_TDO;
    logic                TDO;
    logic                TDO_En;
    logic [IR_WIDTH-1:0] Instr;
    logic                CaptureDR;
    logic                ShiftDR;
    logic                UpdateDR;
    logic                CaptureIR;
    logic                ShiftIR;
    logic                UpdateIR;
    logic                Select;
    logic                Mode;
    logic                BypassSel;
    logic                IdcodeSel;
    logic                BsrSel;
    logic                TLR;

    modport master (
        output TMS, TDI, DR_TDO,
        input  TDO, TDO_En, Instr, CaptureDR, ShiftDR, UpdateDR,
        input  CaptureIR, ShiftIR, UpdateIR, Select, Mode,
        input  BypassSel, IdcodeSel, BsrSel, TLR
    );

    modport slave (
        input  TMS, TDI, DR_TDO,
        output TDO, TDO_En, Instr, CaptureDR, ShiftDR, UpdateDR,
        output CaptureIR, ShiftIR, UpdateIR, Select, Mode,
        output BypassSel, IdcodeSel, BsrSel, TLR
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1-style TAP state machine with instruction register and decode
module jtag_tap_ctrl #(
    parameter int                IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(4'b0000),
    parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(4'b0010),
    parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(4'b0001),
    parameter logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(4'b1111)
) (
    input  logic           TCK,
    input  logic           TRST_n,
    jtag_tap_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        S_TLR, S_RTI,
        S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAUSE_DR, S_EX2_DR, S_UPD_DR,
        S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAUSE_IR, S_EX2_IR, S_UPD_IR
    } tap_state_t;

    tap_state_t          r_state;
    tap_state_t          w_next;
    logic [IR_WIDTH-1:0] r_ir_sr;
    logic [IR_WIDTH-1:0] r_instr;
    logic                w_is_extest;
    logic                w_is_sample;
    logic                w_is_idcode;

    always_comb begin
        w_next = S_TLR;
        case (r_state)
            S_TLR:      w_next = bus.TMS ? S_TLR      : S_RTI;
            S_RTI:      w_next = bus.TMS ? S_SEL_DR   : S_RTI;
            S_SEL_DR:   w_next = bus.TMS ? S_SEL_IR   : S_CAP_DR;
            S_CAP_DR:   w_next = bus.TMS ? S_EX1_DR   : S_SH_DR;
            S_SH_DR:    w_next = bus.TMS ? S_EX1_DR   : S_SH_DR;
            S_EX1_DR:   w_next = bus.TMS ? S_UPD_DR   : S_PAUSE_DR;
            S_PAUSE_DR: w_next = bus.TMS ? S_EX2_DR   : S_PAUSE_DR;
            S_EX2_DR:   w_next = bus.TMS ? S_UPD_DR   : S_SH_DR;
            S_UPD_DR:   w_next = bus.TMS ? S_SEL_DR   : S_RTI;
            S_SEL_IR:   w_next = bus.TMS ? S_TLR      : S_CAP_IR;
            S_CAP_IR:   w_next = bus.TMS ? S_EX1_IR   : S_SH_IR;
            S_SH_IR:    w_next = bus.TMS ? S_EX1_IR   : S_SH_IR;
            S_EX1_IR:   w_next = bus.TMS ? S_UPD_IR   : S_PAUSE_IR;
            S_PAUSE_IR: w_next = bus.TMS ? S_EX2_IR   : S_PAUSE_IR;
            S_EX2_IR:   w_next = bus.TMS ? S_UPD_IR   : S_SH_IR;
            S_UPD_IR:   w_next = bus.TMS ? S_SEL_DR   : S_RTI;
            default:    w_next = S_TLR;
        endcase
    end

    // IR register updates act on the edge that ends the named state, so they key off r_state.
    always_ff @(posedge TCK) begin
        if (!TRST_n) begin
            r_state <= S_TLR;
            r_instr <= OP_IDCODE;
            r_ir_sr <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_TLR:    r_instr <= OP_IDCODE;
                S_CAP_IR: r_ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
                S_SH_IR:  r_ir_sr <= {bus.TDI, r_ir_sr[IR_WIDTH-1:1]};
                S_UPD_IR: r_instr <= r_ir_sr;
                default:  ;
            endcase
        end
    end

    assign bus.TLR       = (r_state == S_TLR);
    assign bus.CaptureDR = (r_state == S_CAP_DR);
    assign bus.ShiftDR   = (r_state == S_SH_DR);
    assign bus.UpdateDR  = (r_state == S_UPD_DR);
    assign bus.CaptureIR = (r_state == S_CAP_IR);
    assign bus.ShiftIR   = (r_state == S_SH_IR);
    assign bus.UpdateIR  = (r_state == S_UPD_IR);
    assign bus.Select    = (r_state >= S_SEL_IR);
    assign bus.Instr     = r_instr;

    // Priority order keeps the chain selects one-hot even if opcodes are parameterised to overlap.
    assign w_is_extest   = (r_instr == OP_EXTEST);
    assign w_is_sample   = !w_is_extest && (r_instr == OP_SAMPLE);
    assign w_is_idcode   = !w_is_extest && !w_is_sample && (r_instr == OP_IDCODE);
    assign bus.Mode      = w_is_extest;
    assign bus.BsrSel    = w_is_extest || w_is_sample;
    assign bus.IdcodeSel = w_is_idcode;
    assign bus.BypassSel = !(w_is_extest || w_is_sample || w_is_idcode);

    always_comb begin
        bus.TDO    = 1'b0;
        bus.TDO_En = 1'b0;
        if (r_state == S_SH_IR) begin
            bus.TDO    = r_ir_sr[0];
            bus.TDO_En = 1'b1;
        end else if (r_state == S_SH_DR) begin
            bus.TDO    = bus.DR_TDO;
            bus.TDO_En = 1'b1;
        end
    end

    // OP_BYPASS documents the canonical opcode; every unrecognised opcode already routes to bypass.
    logic w_unused_bypass_op;
    assign w_unused_bypass_op = ^OP_BYPASS;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - self-checking bench for jtag_tap_ctrl with a TDO scoreboard
module tb_jtag_tap_ctrl;
    localparam int IR_W = 4;

    logic TCK = 1'b0;
    logic TRST_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       q_tdo[$];
    logic [3:0] m_ir;
    logic [3:0] m_instr;
    logic       m_chain;
    logic       r_chain;

    jtag_tap_ctrl_if #(.IR_WIDTH(IR_W)) bus ();

    jtag_tap_ctrl #(.IR_WIDTH(IR_W)) dut (
        .TCK   (TCK),
        .TRST_n(TRST_n),
        .bus   (bus)
    );

    always #5 TCK = ~TCK;

    // External one-bit data register chain (bypass-like) feeding DR_TDO.
    always @(posedge TCK) begin
        if (bus.CaptureDR)    r_chain <= 1'b0;
        else if (bus.ShiftDR) r_chain <= bus.TDI;
    end
    assign bus.DR_TDO = r_chain;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge TCK) begin
        if (bus.TDO_En === 1'b1) begin
            if (q_tdo.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic e;
                e = q_tdo.pop_front();
                check_eq("tdo", 32'(bus.TDO), 32'(e));
            end
        end
    end

    task automatic step(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic enter_shir();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("cap_ir", 32'(bus.CaptureIR), 32'd1);
        m_ir = 4'b0001;
        step(1'b0, 1'b0);
        check_eq("sh_ir", 32'(bus.ShiftIR), 32'd1);
        check_eq("sel_ir", 32'(bus.Select), 32'd1);
    endtask

    task automatic shift_ir(input logic [3:0] bits, input int n, input logic exit_last);
        for (int i = 0; i < n; i++) begin
            q_tdo.push_back(m_ir[0]);
            m_ir = {bits[i], m_ir[3:1]};
            step(exit_last && (i == n - 1), bits[i]);
        end
    endtask

    task automatic load_ir(input logic [3:0] op);
        enter_shir();
        shift_ir(op, 4, 1'b1);
        check_eq("instr_hold_ex1", 32'(bus.Instr), 32'(m_instr));
        step(1'b1, 1'b0);
        check_eq("upd_ir", 32'(bus.UpdateIR), 32'd1);
        step(1'b0, 1'b0);
        m_instr = op;
        check_eq("instr_load", 32'(bus.Instr), 32'(m_instr));
    endtask

    task automatic enter_shdr();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_eq("cap_dr", 32'(bus.CaptureDR), 32'd1);
        m_chain = 1'b0;
        step(1'b0, 1'b0);
        check_eq("sh_dr", 32'(bus.ShiftDR), 32'd1);
        check_eq("sel_dr", 32'(bus.Select), 32'd0);
    endtask

    task automatic shift_dr(input logic [4:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            q_tdo.push_back(m_chain);
            m_chain = bits[i];
            step(i == n - 1, bits[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        TRST_n  = 1'b0;
        bus.TMS = 1'b0;
        bus.TDI = 1'b0;
        m_instr = 4'b0001;

        // Reset
        step(1'b0, 1'b0);
        check_eq("rst_tlr", 32'(bus.TLR), 32'd1);
        check_eq("rst_instr", 32'(bus.Instr), 32'h1);
        check_eq("rst_idsel", 32'(bus.IdcodeSel), 32'd1);
        check_eq("rst_mode", 32'(bus.Mode), 32'd0);
        check_eq("rst_tdo_en", 32'(bus.TDO_En), 32'd0);
        check_eq("rst_tdo", 32'(bus.TDO), 32'd0);
        check_eq("rst_select", 32'(bus.Select), 32'd0);
        check_eq("rst_strobes", 32'({bus.CaptureDR, bus.ShiftDR, bus.UpdateDR,
                                     bus.CaptureIR, bus.ShiftIR, bus.UpdateIR}), 32'd0);
        TRST_n = 1'b1;
        step(1'b0, 1'b0);
        check_eq("rti_tlr", 32'(bus.TLR), 32'd0);

        // IR capture pattern with zeros shifted in -> EXTEST
        load_ir(4'b0000);
        check_eq("extest_mode", 32'(bus.Mode), 32'd1);
        check_eq("extest_bsr", 32'(bus.BsrSel), 32'd1);
        check_eq("extest_byp", 32'(bus.BypassSel), 32'd0);

        load_ir(4'b0010);
        check_eq("sample_bsr", 32'(bus.BsrSel), 32'd1);
        check_eq("sample_mode", 32'(bus.Mode), 32'd0);

        // BYPASS data path, one-edge delay through the chain
        load_ir(4'b1111);
        check_eq("bypass_sel", 32'(bus.BypassSel), 32'd1);
        enter_shdr();
        shift_dr(5'b01101, 5);
        step(1'b1, 1'b0);
        check_eq("upd_dr", 32'(bus.UpdateDR), 32'd1);
        step(1'b0, 1'b0);

        load_ir(4'b0101);
        check_eq("undef_bypass", 32'(bus.BypassSel), 32'd1);
        check_eq("undef_onehot", 32'({bus.BsrSel, bus.IdcodeSel}), 32'd0);

        // Escape: four TMS=1 edges from ShDR stay out of TLR, the fifth reaches it
        enter_shdr();
        q_tdo.push_back(m_chain);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        check_eq("esc4_not_tlr", 32'(bus.TLR), 32'd0);
        step(1'b1, 1'b0);
        check_eq("esc5_tlr", 32'(bus.TLR), 32'd1);
        step(1'b1, 1'b0);
        m_instr = 4'b0001;
        check_eq("esc_instr", 32'(bus.Instr), 32'(m_instr));
        check_eq("esc_idsel", 32'(bus.IdcodeSel), 32'd1);
        step(1'b0, 1'b0);

        // Reset in the middle of an IR shift
        load_ir(4'b0000);
        enter_shir();
        shift_ir(4'b0011, 2, 1'b0);
        q_tdo.push_back(m_ir[0]);
        TRST_n = 1'b0;
        step(1'b0, 1'b1);
        TRST_n = 1'b1;
        m_instr = 4'b0001;
        check_eq("midrst_tlr", 32'(bus.TLR), 32'd1);
        check_eq("midrst_instr", 32'(bus.Instr), 32'(m_instr));
        check_eq("midrst_shir", 32'(bus.ShiftIR), 32'd0);
        check_eq("midrst_tdo_en", 32'(bus.TDO_En), 32'd0);
        step(1'b0, 1'b0);

        // Reset wins over the UpdIR edge
        enter_shir();
        shift_ir(4'b0000, 2, 1'b0);
        shift_ir(4'b0000, 2, 1'b1);
        step(1'b1, 1'b0);
        check_eq("upd_ir2", 32'(bus.UpdateIR), 32'd1);
        TRST_n = 1'b0;
        step(1'b0, 1'b0);
        TRST_n = 1'b1;
        check_eq("rst_over_upd", 32'(bus.Instr), 32'(m_instr));
        check_eq("rst_over_upd_tlr", 32'(bus.TLR), 32'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        check_eq("sb_drained", 32'(q_tdo.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- IEEE 1149.1-style TAP controller that sequences the boundary-scan datapath.
- Runs the 16-state TAP FSM from TMS and owns the instruction register and its decode.
- Drives the capture/shift/update strobes of the data registers, the Mode select of the boundary-scan cell muxes, and the IR/DR select of the TDO output mux.
- Sits between the chip's JTAG pins and the boundary/bypass/IDCODE register chains.

Parameters:
- IR_WIDTH, 4, instruction register width (≥2).
- OP_EXTEST, 4'b0000, EXTEST opcode.
- OP_SAMPLE, 4'b0010, SAMPLE/PRELOAD opcode.
- OP_IDCODE, 4'b0001, IDCODE opcode (reset instruction).
- OP_BYPASS, 4'b1111, BYPASS opcode; any undefined opcode also decodes as BYPASS.

Ports:
- TCK  in  1  sole clock; all state changes on rising edge.
- TRST_n  in  1  synchronous active-low reset, sampled on TCK rising edge.
- TMS  in  1  mode select.
- TDI  in  1  serial data in.
- DR_TDO  in  1  serial out of the currently selected data register chain.
- TDO  out  1  serial data out.
- TDO_En  out  1  output enable for the TDO pad.
- Instr  out  IR_WIDTH  current latched instruction.
- CaptureDR / ShiftDR / UpdateDR  out  1 each  DR strobes.
- CaptureIR / ShiftIR / UpdateIR  out  1 each  IR strobes.
- Select  out  1  TDO mux select: 0=DR path, 1=IR path.
- Mode  out  1  boundary-cell output mux select: 1 when Instr decodes EXTEST.
- BypassSel / IdcodeSel / BsrSel  out  1 each  one-hot DR chain select.
- TLR  out  1  high while the FSM is in Test-Logic-Reset.

Behaviour:
- FSM states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- Transitions (TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SelDR
  - SelDR: CapDR / SelIR
  - CapDR: ShDR / Ex1DR
  - ShDR: ShDR / Ex1DR
  - Ex1DR: PauseDR / UpdDR
  - PauseDR: PauseDR / Ex2DR
  - Ex2DR: ShDR / UpdDR
  - UpdDR: RTI / SelDR
  - SelIR: CapIR / TLR
  - CapIR: ShIR / Ex1IR
  - ShIR: ShIR / Ex1IR
  - Ex1IR: PauseIR / UpdIR
  - PauseIR: PauseIR / Ex2IR
  - Ex2IR: ShIR / UpdIR
  - UpdIR: RTI / SelDR
- Five consecutive TMS=1 edges reach TLR from any state.
- Strobes are Moore outputs decoded from the current state: CaptureDR=CapDR, ShiftDR=ShDR, UpdateDR=UpdDR, and likewise for IR. Each is high for exactly the cycles spent in that state, so the consuming register acts on the rising edge that ends the state.
- Select=1 in SelIR..UpdIR states, else 0. TLR=1 only in TLR.
- IR shift register (IR_WIDTH bits):
  - At the edge ending CapIR: loads {zeros, 2'b01}, so LSB=1 and bit1=0.
  - At the edge ending ShIR: shifts right, TDI enters MSB.
  - Held in all other states.
- Instr:
  - Loaded from the IR shift register at the edge ending UpdIR.
  - Forced to OP_IDCODE on every edge in TLR.
  - Otherwise held. Instr never changes during shifting.
- Decode is combinational from Instr:
  - EXTEST → BsrSel=1, Mode=1.
  - SAMPLE → BsrSel=1, Mode=0.
  - IDCODE → IdcodeSel=1.
  - Anything else → BypassSel=1.
  - Exactly one select is high at all times.
- TDO is combinational:
  - ShIR: TDO=IR shift reg bit0, TDO_En=1.
  - ShDR: TDO=DR_TDO, TDO_En=1.
  - Otherwise TDO=0, TDO_En=0.
- Reset: TRST_n=0 at a rising edge puts FSM in TLR, Instr=OP_IDCODE and the IR shift register to 0, overriding TMS.
  - Post-reset outputs: TLR=1, all strobes 0, Select=0, Mode=0, IdcodeSel=1, TDO=0, TDO_En=0.
- Reset mid-shift abandons the operation; Instr is not updated.
- TRST_n=0 has priority over every state transition, including UpdIR.

Test Plan:
- Reset: TRST_n=0 for 1 edge with TMS=0 → TLR=1, Instr=4'b0001, IdcodeSel=1, Mode=0, TDO_En=0. The next TMS=0 edge reaches RTI and TLR drops.
- Escape to TLR: from ShDR apply TMS=1 ×5 → TLR=1 after the 5th edge. TMS=1 ×4 from ShDR → not in TLR.
- IR capture: RTI, TMS 1,1,0,0 → ShIR. Shift 4 edges with TDI=0 → TDO sequence 1,0,0,0, TDO_En=1 throughout ShIR.
- EXTEST load: shift 4'b0000 into IR, then Ex1IR→UpdIR→RTI → Instr=0000, Mode=1, BsrSel=1 after the UpdIR edge; Instr remains 0001 while in Ex1IR.
- BYPASS path: load 4'b1111, enter ShDR with DR_TDO tied to a 1-bit register fed from TDI; shift 1,0,1,1 → TDO 1,0,1,1 delayed one edge, Select=0, BypassSel=1. Undefined opcode 4'b0101 → also BypassSel=1.
- Reset mid-operation: in ShIR after 2 shift edges, assert TRST_n=0 → next edge TLR=1, Instr=0001, ShiftIR=0, TDO_En=0. A subsequent IR capture again yields TDO pattern 1,0.
